// File: rtl/dmem_store_buffer.sv
// MEM-stage store buffer: stores retire into a FIFO and drain to a handshaked memory; loads block.
// Optional macro DMEM_STBUF_FWD_EN forwards loads that hit a buffered store.
module dmem_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            data_adr,
   input  logic [31:0]            data_out,
   output logic [31:0]            data_in,
   output logic                   mem_stall,
   output logic                   mreq,
   output logic                   mwe,
   output logic [31:0]            maddr,
   output logic [31:0]            mwdata,
   input  logic [31:0]            mrdata,
   input  logic                   mack,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        st;
   logic [29:0]   adr_q [DEPTH];
   logic [31:0]   dat_q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   cnt;

   logic          is_store;
   logic          is_load;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          hit;
   logic [31:0]   hit_data;
   logic          load_go;
   logic          load_done;
   logic          unused_bits;

   assign state       = st;
   assign count       = cnt;
   assign unused_bits = ^data_adr[1:0];

   // A simultaneous read and write is handled as a write.
   assign is_store = mem_write;
   assign is_load  = mem_read & ~mem_write;
   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign push     = is_store & ~full;
   assign pop      = (st == DRAIN) & mack;

`ifdef DMEM_STBUF_FWD_EN
   logic [AW-1:0] idx;

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (is_load && ((AW+1)'(i) < cnt) && (adr_q[idx] == data_adr[31:2])) begin
            hit      = 1'b1;
            hit_data = dat_q[idx];
         end
      end
   end

   assign load_go = is_load & ~hit;
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
   // Loads wait for the buffer to empty, which also gives draining priority.
   assign load_go  = is_load & empty;
`endif

   assign load_done = is_load & (st == LOAD) & mack;
   assign data_in   = load_done ? mrdata : (hit ? hit_data : 32'h0);
   assign mem_stall = (is_store & full) | (is_load & ~hit & ~load_done);

   always_ff @(posedge clk) begin
      if (push) begin
         adr_q[tail] <= data_adr[31:2];
         dat_q[tail] <= data_out;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Memory handshake: mreq/mwe/maddr/mwdata are held from issue until the cycle
   // mack is seen; mack is a one-cycle pulse and is ignored while IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st     <= IDLE;
         mreq   <= 1'b0;
         mwe    <= 1'b0;
         maddr  <= '0;
         mwdata <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (load_go) begin
                  st    <= LOAD;
                  mreq  <= 1'b1;
                  mwe   <= 1'b0;
                  maddr <= {data_adr[31:2], 2'b00};
               end else if (!empty) begin
                  st     <= DRAIN;
                  mreq   <= 1'b1;
                  mwe    <= 1'b1;
                  maddr  <= {adr_q[head], 2'b00};
                  mwdata <= dat_q[head];
               end
            end
            LOAD, DRAIN: begin
               if (mack) begin
                  st   <= IDLE;
                  mreq <= 1'b0;
                  mwe  <= 1'b0;
               end
            end
            default: begin
               st   <= IDLE;
               mreq <= 1'b0;
               mwe  <= 1'b0;
            end
         endcase
      end
   end

endmodule
